// File: rtl/pmem_acc_ctrl_pkg.sv
// Shared defaults and read-port owner encoding for the psum accumulate controller.
package pmem_acc_ctrl_pkg;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF = 8;

    typedef enum logic {
        ARB_ACC   = 1'b0,
        ARB_DRAIN = 1'b1
    } arb_own_e;
endpackage

// File: rtl/pmem_acc_ctrl_if.sv
// Accumulate, drain and psum-memory signals of the controller, seen from both sides.
interface pmem_acc_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                  i_acc_valid;
    logic                  o_acc_ready;
    logic [ADDR_WIDTH-1:0] i_acc_addr;
    logic [DATA_WIDTH-1:0] i_acc_data;
    logic                  i_acc_first;
    logic                  i_drain_req;
    logic                  o_drain_gnt;
    logic [ADDR_WIDTH-1:0] i_drain_addr;
    logic                  o_drain_valid;
    logic [DATA_WIDTH-1:0] o_drain_data;
    logic                  o_mem_rd_en;
    logic [ADDR_WIDTH-1:0] o_mem_rd_addr;
    logic [DATA_WIDTH-1:0] i_mem_rd_data;
    logic                  o_mem_wr_en;
    logic [ADDR_WIDTH-1:0] o_mem_wr_addr;
    logic [DATA_WIDTH-1:0] o_mem_wr_data;
    logic                  o_busy;

    modport slave (
        input  i_acc_valid, i_acc_addr, i_acc_data, i_acc_first,
        input  i_drain_req, i_drain_addr, i_mem_rd_data,
        output o_acc_ready, o_drain_gnt, o_drain_valid, o_drain_data,
        output o_mem_rd_en, o_mem_rd_addr, o_mem_wr_en, o_mem_wr_addr, o_mem_wr_data,
        output o_busy
    );

    modport master (
        output i_acc_valid, i_acc_addr, i_acc_data, i_acc_first,
        output i_drain_req, i_drain_addr, i_mem_rd_data,
        input  o_acc_ready, o_drain_gnt, o_drain_valid, o_drain_data,
        input  o_mem_rd_en, o_mem_rd_addr, o_mem_wr_en, o_mem_wr_addr, o_mem_wr_data,
        input  o_busy
    );
endinterface

// File: rtl/pmem_acc_ctrl_rr_arb2.sv
// Two-requester round-robin; the last-grant pointer only moves when both request.
module pmem_rr_arb2
    import pmem_acc_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);
    arb_own_e last_q, last_d;

    always_comb begin
        o_gnt  = i_req;
        last_d = last_q;
        if (i_req[ARB_ACC] && i_req[ARB_DRAIN]) begin
            if (last_q == ARB_DRAIN) begin
                o_gnt  = 2'b01;
                last_d = ARB_ACC;
            end else begin
                o_gnt  = 2'b10;
                last_d = ARB_DRAIN;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) last_q <= ARB_DRAIN;
        else          last_q <= last_d;
    end
endmodule

// File: rtl/pmem_acc_ctrl.sv
// Psum read-modify-write controller: S0 issues reads (shared with drain), S1 adds and writes.
module pmem_acc_ctrl
    import pmem_acc_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    pmem_acc_ctrl_if.slave   bus
);
    logic [1:0]            req, gnt;
    logic                  acc_fire, rd_fwd;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] operand, wr_data;

    logic                  s1_vld_q, s1_vld_d;
    logic                  s1_first_q, s1_first_d;
    logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic                  s1_fwd_q, s1_fwd_d;
    logic                  drn_vld_q, drn_vld_d;
    logic                  drn_fwd_q, drn_fwd_d;
    logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;

    pmem_rr_arb2 u_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   (req),
        .o_gnt   (gnt)
    );

    // Overwrite requests never touch the read port, so they ride alongside a drain.
    assign req[ARB_ACC]   = bus.i_acc_valid & ~bus.i_acc_first;
    assign req[ARB_DRAIN] = bus.i_drain_req;
    assign acc_fire       = bus.i_acc_valid & (bus.i_acc_first | gnt[ARB_ACC]);
    assign rd_addr        = gnt[ARB_ACC] ? bus.i_acc_addr : bus.i_drain_addr;

    // A read colliding with this cycle's write takes the write data next cycle.
    assign rd_fwd  = s1_vld_q & (s1_addr_q == rd_addr);
    assign operand = s1_fwd_q ? fwd_data_q : bus.i_mem_rd_data;
    assign wr_data = s1_first_q ? s1_data_q : operand + s1_data_q;

    assign bus.o_acc_ready   = acc_fire;
    assign bus.o_drain_gnt   = gnt[ARB_DRAIN];
    assign bus.o_mem_rd_en   = |gnt;
    assign bus.o_mem_rd_addr = rd_addr;
    assign bus.o_mem_wr_en   = s1_vld_q & i_rst_n;
    assign bus.o_mem_wr_addr = s1_addr_q;
    assign bus.o_mem_wr_data = wr_data;
    assign bus.o_drain_valid = drn_vld_q;
    assign bus.o_drain_data  = drn_fwd_q ? fwd_data_q : bus.i_mem_rd_data;
    assign bus.o_busy        = s1_vld_q;

    always_comb begin
        s1_vld_d   = acc_fire;
        s1_first_d = bus.i_acc_first;
        s1_addr_d  = bus.i_acc_addr;
        s1_data_d  = bus.i_acc_data;
        s1_fwd_d   = rd_fwd & gnt[ARB_ACC];
        drn_vld_d  = gnt[ARB_DRAIN];
        drn_fwd_d  = rd_fwd & gnt[ARB_DRAIN];
        fwd_data_d = wr_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_data_q  <= '0;
            s1_fwd_q   <= 1'b0;
            drn_vld_q  <= 1'b0;
            drn_fwd_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_first_q <= s1_first_d;
            s1_addr_q  <= s1_addr_d;
            s1_data_q  <= s1_data_d;
            s1_fwd_q   <= s1_fwd_d;
            drn_vld_q  <= drn_vld_d;
            drn_fwd_q  <= drn_fwd_d;
            fwd_data_q <= fwd_data_d;
        end
    end
endmodule

// File: tb/tb_pmem_acc_ctrl.sv
// Directed bench: scoreboard of expected writes/drain data against a reference memory.
module tb_pmem_acc_ctrl;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int DEPTH = 2**AW;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic seed_en = 1'b0;
    always #5 clk = ~clk;

    pmem_acc_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    pmem_acc_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    logic [DW-1:0] mem   [DEPTH];
    logic [DW-1:0] ref_m [DEPTH];
    wr_t           wq[$];
    logic [DW-1:0] dq[$];
    wr_t           w_pop;
    logic [DW-1:0] d_pop, nv;
    int total = 0;
    int bad = 0;
    int n_wr = 0;

    function automatic logic [DW-1:0] seed(int i);
        return DW'(i * 37 + 11);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory with registered read; a same-cycle write is not visible to the read.
    always @(posedge clk) begin
        if (seed_en) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= seed(i);
        end else begin
            if (bus.o_mem_rd_en) bus.i_mem_rd_data <= mem[bus.o_mem_rd_addr];
            if (bus.o_mem_wr_en) mem[bus.o_mem_wr_addr] <= bus.o_mem_wr_data;
        end
    end

    // Drain grants see the model before this cycle's accepts are applied.
    always @(negedge clk) begin
        if (seed_en)
            for (int i = 0; i < DEPTH; i++) ref_m[i] = seed(i);
        if (!rst_n) begin
            wq.delete();
            dq.delete();
        end else begin
            if (bus.o_mem_wr_en) begin
                n_wr++;
                if (wq.size() == 0) chk("wr_unexpected", 32'(bus.o_mem_wr_en), 0);
                else begin
                    w_pop = wq.pop_front();
                    chk("wr_addr", 32'(bus.o_mem_wr_addr), 32'(w_pop.a));
                    chk("wr_data", 32'(bus.o_mem_wr_data), 32'(w_pop.d));
                end
            end
            if (bus.o_drain_valid) begin
                if (dq.size() == 0) chk("drain_unexpected", 32'(bus.o_drain_valid), 0);
                else begin
                    d_pop = dq.pop_front();
                    chk("drain_data", 32'(bus.o_drain_data), 32'(d_pop));
                end
            end
            if (bus.o_drain_gnt) dq.push_back(ref_m[bus.i_drain_addr]);
            if (bus.i_acc_valid && bus.o_acc_ready) begin
                nv = bus.i_acc_first ? bus.i_acc_data : ref_m[bus.i_acc_addr] + bus.i_acc_data;
                ref_m[bus.i_acc_addr] = nv;
                wq.push_back('{bus.i_acc_addr, nv});
            end
        end
    end

    task automatic idle();
        bus.i_acc_valid  = 1'b0;
        bus.i_acc_first  = 1'b0;
        bus.i_acc_addr   = '0;
        bus.i_acc_data   = '0;
        bus.i_drain_req  = 1'b0;
        bus.i_drain_addr = '0;
    endtask

    task automatic acc(int a, int d, bit f);
        bus.i_acc_valid = 1'b1;
        bus.i_acc_addr  = AW'(a);
        bus.i_acc_data  = DW'(d);
        bus.i_acc_first = f;
    endtask

    task automatic drain(int a);
        bus.i_drain_req  = 1'b1;
        bus.i_drain_addr = AW'(a);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nw0, acc_g, drn_g, pend;
        idle();
        rst_n   = 1'b0;
        seed_en = 1'b1;
        @(negedge clk);
        next();
        seed_en = 1'b0;
        next();
        @(negedge clk);
        chk("rst_busy", 32'(bus.o_busy), 0);
        chk("rst_drain_valid", 32'(bus.o_drain_valid), 0);
        chk("rst_wr_en", 32'(bus.o_mem_wr_en), 0);
        chk("rst_rd_en", 32'(bus.o_mem_rd_en), 0);
        chk("rst_ready", 32'(bus.o_acc_ready), 0);
        next();
        rst_n = 1'b1;

        // overwrite then accumulate to the same address on the next cycle
        acc(5, 10, 1'b1);
        @(negedge clk);
        chk("t1_first_no_rd", 32'(bus.o_mem_rd_en), 0);
        next();
        acc(5, 3, 1'b0);
        @(negedge clk);
        chk("t1_ready", 32'(bus.o_acc_ready), 1);
        chk("t1_rd_en", 32'(bus.o_mem_rd_en), 1);
        next(); idle(); next(); next();
        chk("t1_mem5", 32'(mem[5]), 13);

        // back-to-back running sum
        nw0 = n_wr;
        acc(7, 0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            next();
            acc(7, k, 1'b0);
            @(negedge clk);
            chk("t2_wr_each_cycle", 32'(bus.o_mem_wr_en), 1);
        end
        next(); idle(); next(); next();
        chk("t2_mem7", 32'(mem[7]), 10);
        chk("t2_write_count", 32'(n_wr - nw0), 5);

        // contention: acc wins first (pointer resets to drain), then alternates
        acc(3, 100, 1'b1);
        next();
        acc_g = 0; drn_g = 0; pend = 1;
        for (int c = 0; c < 4; c++) begin
            acc(3, pend, 1'b0);
            drain(3);
            @(negedge clk);
            chk("t3_acc_gnt", 32'(bus.o_acc_ready), 32'(c % 2 == 0));
            chk("t3_drain_gnt", 32'(bus.o_drain_gnt), 32'(c % 2 == 1));
            if (bus.o_acc_ready) begin acc_g++; pend++; end
            if (bus.o_drain_gnt) drn_g++;
            next();
        end
        idle(); next(); next();
        chk("t3_acc_total", 32'(acc_g), 2);
        chk("t3_drain_total", 32'(drn_g), 2);
        chk("t3_mem3", 32'(mem[3]), 103);

        // overwrite concurrent with drain of the same address
        acc(2, 9, 1'b1);
        drain(2);
        @(negedge clk);
        chk("t4_ready", 32'(bus.o_acc_ready), 1);
        chk("t4_gnt", 32'(bus.o_drain_gnt), 1);
        next();
        bus.i_acc_valid = 1'b0;
        @(negedge clk);
        chk("t4_dvalid_old", 32'(bus.o_drain_valid), 1);
        chk("t4_old_value", 32'(bus.o_drain_data), 32'(seed(2)));
        next(); idle();
        @(negedge clk);
        chk("t4_dvalid_new", 32'(bus.o_drain_valid), 1);
        chk("t4_new_value", 32'(bus.o_drain_data), 9);
        next();

        // wraparound
        acc(0, 16'hFFFF, 1'b1);
        next();
        acc(0, 2, 1'b0);
        next(); idle(); next(); next();
        chk("t5_wrap", 32'(mem[0]), 1);

        // reset while the RMW sits in S1
        acc(9, 5, 1'b0);
        next();
        idle();
        drain(9);
        rst_n = 1'b0;
        next();
        idle();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t6_wr_en", 32'(bus.o_mem_wr_en), 0);
            chk("t6_drain_valid", 32'(bus.o_drain_valid), 0);
            chk("t6_busy", 32'(bus.o_busy), 0);
            next();
        end
        chk("t6_mem9_untouched", 32'(mem[9]), 32'(seed(9)));
        chk("sb_writes_drained", 32'(wq.size()), 0);
        chk("sb_drains_drained", 32'(dq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
